// File: rtl/magic_readback_if.sv
// CPU bus signals as seen by the magic-port read-back block.
interface cpu_bus;
    logic        mreq;
    logic        ioreq;
    logic        rd;
    logic        wr;
    logic        m1;
    logic [15:0] a;

    modport slave (input mreq, input ioreq, input rd, input wr, input m1, input a);
endinterface

// File: rtl/magic_readback.sv
// Read side of the magic config port (xxFF): snapshots config state, event flags
// and counters onto d_out_o while the magic ROM is mapped. The 0x0C and 0x0D reads
// clear their events at the end of a completed read. Events that arrive after the
// snapshot are remembered in the pend_* registers and survive the clear.
module magic_readback #(
    parameter int unsigned BTN_CNT_W = 4,
    parameter logic [7:0]  ID_BYTE   = 8'h5A
) (
    input  logic       clk28,
    input  logic       rst_n,
    cpu_bus.slave      bus,
    input  logic       n_int_i,
    input  logic       n_int_next_i,
    input  logic       magic_button_i,
    input  logic       magic_map_i,
    input  logic       cfg_magic_beeper_i,
    input  logic [1:0] cfg_timings_i,
    input  logic [1:0] cfg_turbo_i,
    input  logic [1:0] cfg_panning_i,
    input  logic       cfg_rom_plus3_i,
    input  logic       cfg_rom_alt48_i,
    input  logic       cfg_joy_sinclair_i,
    input  logic [1:0] cfg_ram_mode_i,
    input  logic       cfg_divmmc_en_i,
    input  logic       cfg_ulaplus_en_i,
    input  logic       cfg_covox_en_i,
    input  logic       cfg_sd_en_i,
    output logic [7:0] d_out_o,
    output logic       d_out_active_o
);
    localparam logic [BTN_CNT_W-1:0] BTN_MAX = '1;
    localparam logic [BTN_CNT_W-1:0] BTN_ONE = BTN_CNT_W'(1);

    logic                 cs, rd_start, rd_end, tick, press, ovf_now;
    logic [7:0]           rd_mux;
    logic                 unused_bus;

    logic                 cs_q;
    logic [7:0]           d_out_q, d_out_d;
    logic [7:0]           rd_addr_q, rd_addr_d;
    logic [7:0]           frame_cnt_q, frame_cnt_d;
    logic                 frame_evt_q, frame_evt_d;
    logic                 frame_ovf_q, frame_ovf_d;
    logic                 btn_evt_q, btn_evt_d;
    logic                 btn_prev_q, btn_prev_d;
    logic [BTN_CNT_W-1:0] btn_cnt_q, btn_cnt_d;
    logic                 pend_frame_evt_q, pend_frame_evt_d;
    logic                 pend_frame_ovf_q, pend_frame_ovf_d;
    logic                 pend_btn_evt_q, pend_btn_evt_d;
    logic [BTN_CNT_W-1:0] pend_btn_cnt_q, pend_btn_cnt_d;

    // Decode and event detection; m1 and wr deliberately play no part in the decode.
    always_comb begin
        cs       = magic_map_i & bus.ioreq & bus.rd & (bus.a[7:0] == 8'hFF);
        rd_start = cs & ~cs_q;
        rd_end   = ~cs & cs_q;
        tick     = n_int_i & ~n_int_next_i;
        press    = tick & magic_button_i & ~btn_prev_q;
        ovf_now  = tick & (frame_cnt_q == 8'hFF);
    end

    assign unused_bus = bus.mreq ^ bus.wr ^ bus.m1;

    // Register map as seen through a[15:8].
    always_comb begin
        rd_mux = 8'hFF;
        case (bus.a[15:8])
            8'h00: rd_mux = 8'h00;
            8'h01: rd_mux = {7'b0, cfg_magic_beeper_i};
            8'h02: rd_mux = {6'b0, cfg_timings_i};
            8'h03: rd_mux = {6'b0, cfg_turbo_i};
            8'h04: rd_mux = {6'b0, cfg_panning_i};
            8'h05: rd_mux = {7'b0, cfg_rom_plus3_i};
            8'h06: rd_mux = {7'b0, cfg_rom_alt48_i};
            8'h07: rd_mux = {7'b0, cfg_joy_sinclair_i};
            8'h08: rd_mux = {6'b0, cfg_ram_mode_i};
            8'h09: rd_mux = {7'b0, cfg_divmmc_en_i};
            8'h0A: rd_mux = {7'b0, cfg_ulaplus_en_i};
            8'h0B: rd_mux = {6'b0, cfg_sd_en_i, cfg_covox_en_i};
            8'h0C: rd_mux = {5'b0, frame_ovf_q, frame_evt_q, btn_evt_q};
            8'h0D: rd_mux = 8'(btn_cnt_q);
            8'h0E: rd_mux = frame_cnt_q;
            8'h0F: rd_mux = ID_BYTE;
            default: rd_mux = 8'hFF;
        endcase
    end

    // Next state for counters, flags, the pending-merge shadow and the read snapshot.
    always_comb begin
        d_out_d     = rd_start ? rd_mux : d_out_q;
        rd_addr_d   = rd_start ? bus.a[15:8] : rd_addr_q;
        frame_cnt_d = frame_cnt_q + 8'(tick);
        btn_prev_d  = tick ? magic_button_i : btn_prev_q;
        frame_evt_d = frame_evt_q | tick;
        frame_ovf_d = frame_ovf_q | ovf_now;
        btn_evt_d   = btn_evt_q | press;
        btn_cnt_d   = (press && btn_cnt_q != BTN_MAX) ? btn_cnt_q + BTN_ONE : btn_cnt_q;

        // The shadow restarts at the snapshot, so it holds exactly what the read did not see.
        if (rd_start) begin
            pend_frame_evt_d = tick;
            pend_frame_ovf_d = ovf_now;
            pend_btn_evt_d   = press;
            pend_btn_cnt_d   = BTN_CNT_W'(press);
        end else begin
            pend_frame_evt_d = pend_frame_evt_q | tick;
            pend_frame_ovf_d = pend_frame_ovf_q | ovf_now;
            pend_btn_evt_d   = pend_btn_evt_q | press;
            pend_btn_cnt_d   = (press && pend_btn_cnt_q != BTN_MAX) ?
                               pend_btn_cnt_q + BTN_ONE : pend_btn_cnt_q;
        end

        // Clear-on-read: replacing with the shadow means a same-cycle event still wins.
        if (rd_end && rd_addr_q == 8'h0C) begin
            frame_evt_d = pend_frame_evt_d;
            frame_ovf_d = pend_frame_ovf_d;
            btn_evt_d   = pend_btn_evt_d;
        end
        if (rd_end && rd_addr_q == 8'h0D) begin
            btn_cnt_d = pend_btn_cnt_d;
        end
    end

    // State registers; asynchronous reset releases the bus at once without any clear.
    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            cs_q             <= 1'b0;
            d_out_q          <= 8'hFF;
            rd_addr_q        <= 8'h00;
            frame_cnt_q      <= 8'h00;
            frame_evt_q      <= 1'b0;
            frame_ovf_q      <= 1'b0;
            btn_evt_q        <= 1'b0;
            btn_prev_q       <= 1'b0;
            btn_cnt_q        <= '0;
            pend_frame_evt_q <= 1'b0;
            pend_frame_ovf_q <= 1'b0;
            pend_btn_evt_q   <= 1'b0;
            pend_btn_cnt_q   <= '0;
        end else begin
            cs_q             <= cs;
            d_out_q          <= d_out_d;
            rd_addr_q        <= rd_addr_d;
            frame_cnt_q      <= frame_cnt_d;
            frame_evt_q      <= frame_evt_d;
            frame_ovf_q      <= frame_ovf_d;
            btn_evt_q        <= btn_evt_d;
            btn_prev_q       <= btn_prev_d;
            btn_cnt_q        <= btn_cnt_d;
            pend_frame_evt_q <= pend_frame_evt_d;
            pend_frame_ovf_q <= pend_frame_ovf_d;
            pend_btn_evt_q   <= pend_btn_evt_d;
            pend_btn_cnt_q   <= pend_btn_cnt_d;
        end
    end

    // Drive enable is cs delayed one clock: rises a clock after cs, falls a clock after it drops.
    assign d_out_active_o = cs_q;
    assign d_out_o        = d_out_q;
endmodule

// File: tb/tb_magic_readback.sv
// Scoreboard bench for magic_readback: a driver process issues reads, ticks and
// button activity while updating an event-level model; a monitor checks each read.
module tb_magic_readback;
    localparam int BTN_W   = 4;
    localparam int BTN_MAX = (1 << BTN_W) - 1;

    logic clk28 = 1'b0;
    always #18 clk28 = ~clk28;

    logic       rst_n;
    logic       n_int, n_int_next, magic_button, magic_map;
    logic       cfg_beeper, cfg_plus3, cfg_alt48, cfg_joy, cfg_divmmc, cfg_ulaplus, cfg_covox, cfg_sd;
    logic [1:0] cfg_timings, cfg_turbo, cfg_panning, cfg_ram_mode;
    logic [7:0] d_out;
    logic       d_out_active;
    logic [7:0] a_lo;

    cpu_bus bus_if();

    magic_readback #(.BTN_CNT_W(BTN_W), .ID_BYTE(8'h5A)) dut (
        .clk28(clk28), .rst_n(rst_n), .bus(bus_if),
        .n_int_i(n_int), .n_int_next_i(n_int_next),
        .magic_button_i(magic_button), .magic_map_i(magic_map),
        .cfg_magic_beeper_i(cfg_beeper), .cfg_timings_i(cfg_timings), .cfg_turbo_i(cfg_turbo),
        .cfg_panning_i(cfg_panning), .cfg_rom_plus3_i(cfg_plus3), .cfg_rom_alt48_i(cfg_alt48),
        .cfg_joy_sinclair_i(cfg_joy), .cfg_ram_mode_i(cfg_ram_mode), .cfg_divmmc_en_i(cfg_divmmc),
        .cfg_ulaplus_en_i(cfg_ulaplus), .cfg_covox_en_i(cfg_covox), .cfg_sd_en_i(cfg_sd),
        .d_out_o(d_out), .d_out_active_o(d_out_active)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] exp_q[$];

    // Model state: event flags and counters, plus what has happened since the last snapshot.
    int m_frame, m_bcnt, p_bcnt;
    bit m_fevt, m_fovf, m_bevt, m_bprev, m_cs;
    bit p_fevt, p_fovf, p_bevt;
    logic [7:0] m_hi;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_frame = 0; m_bcnt = 0; p_bcnt = 0;
        m_fevt = 0; m_fovf = 0; m_bevt = 0; m_bprev = 0; m_cs = 0;
        p_fevt = 0; p_fovf = 0; p_bevt = 0; m_hi = 8'h00;
    endtask

    function automatic logic [7:0] exp_val(input logic [7:0] hi);
        case (hi)
            8'h00: return 8'h00;
            8'h01: return {7'b0, cfg_beeper};
            8'h02: return {6'b0, cfg_timings};
            8'h03: return {6'b0, cfg_turbo};
            8'h04: return {6'b0, cfg_panning};
            8'h05: return {7'b0, cfg_plus3};
            8'h06: return {7'b0, cfg_alt48};
            8'h07: return {7'b0, cfg_joy};
            8'h08: return {6'b0, cfg_ram_mode};
            8'h09: return {7'b0, cfg_divmmc};
            8'h0A: return {7'b0, cfg_ulaplus};
            8'h0B: return {6'b0, cfg_sd, cfg_covox};
            8'h0C: return {5'b0, m_fovf, m_fevt, m_bevt};
            8'h0D: return 8'(m_bcnt);
            8'h0E: return 8'(m_frame);
            8'h0F: return 8'h5A;
            default: return 8'hFF;
        endcase
    endfunction

    // One clock: drive inputs, let the edge happen, advance the model, check the drive enable.
    task automatic step(input bit tk, input bit cs_on, input logic [7:0] hi);
        bit cs_eff, st, en, eo, eb;
        bus_if.a     = {hi, a_lo};
        bus_if.ioreq = cs_on;
        bus_if.rd    = cs_on;
        n_int        = 1'b1;
        n_int_next   = !tk;
        @(posedge clk28);
        cs_eff = cs_on && magic_map && (a_lo == 8'hFF);
        st = cs_eff && !m_cs;
        en = !cs_eff && m_cs;
        eo = tk && (m_frame == 255);
        eb = tk && magic_button && !m_bprev;
        if (st) begin
            exp_q.push_back(exp_val(hi));
            m_hi = hi;
            p_fevt = tk; p_fovf = eo; p_bevt = eb; p_bcnt = eb ? 1 : 0;
        end else if (m_cs) begin
            p_fevt |= tk; p_fovf |= eo; p_bevt |= eb;
            if (eb && p_bcnt < BTN_MAX) p_bcnt++;
        end
        if (tk) m_fevt = 1;
        if (eo) m_fovf = 1;
        if (eb) begin
            m_bevt = 1;
            if (m_bcnt < BTN_MAX) m_bcnt++;
        end
        if (tk) begin
            m_frame = (m_frame + 1) % 256;
            m_bprev = magic_button;
        end
        if (en && m_hi == 8'h0C) begin
            m_fevt = p_fevt; m_fovf = p_fovf; m_bevt = p_bevt;
        end
        if (en && m_hi == 8'h0D) m_bcnt = p_bcnt;
        m_cs = cs_eff;
        #1;
        check("active", d_out_active, m_cs);
    endtask

    task automatic rd(input logic [7:0] hi, input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, hi);
        step(1'b0, 1'b0, hi);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b1, 1'b0, 8'h00);
            step(1'b0, 1'b0, 8'h00);
        end
    endtask

    task automatic rand_cfg();
        cfg_beeper = 1'($urandom); cfg_plus3 = 1'($urandom); cfg_alt48 = 1'($urandom);
        cfg_joy = 1'($urandom); cfg_divmmc = 1'($urandom); cfg_ulaplus = 1'($urandom);
        cfg_covox = 1'($urandom); cfg_sd = 1'($urandom);
        cfg_timings = 2'($urandom); cfg_turbo = 2'($urandom);
        cfg_panning = 2'($urandom); cfg_ram_mode = 2'($urandom);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus_if.ioreq = 1'b0; bus_if.rd = 1'b0;
        n_int = 1'b1; n_int_next = 1'b1;
        repeat (2) @(posedge clk28);
        #1;
        check("reset_d_out", d_out, 8'hFF);
        check("reset_active", d_out_active, 1'b0);
        rst_n = 1'b1;
        model_reset();
    endtask

    // Monitor: pop an expectation on each new read, then require the data to hold.
    logic       act_prev = 1'b0;
    logic [7:0] cur_exp  = 8'h00;
    always @(negedge clk28) begin
        if (d_out_active && !act_prev) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_read: got d_out %0h with nothing expected at %0t", d_out, $time);
            end else begin
                cur_exp = exp_q.pop_front();
                check("read_data", d_out, cur_exp);
            end
        end else if (d_out_active) begin
            check("read_hold", d_out, cur_exp);
        end
        act_prev = d_out_active;
    end

    initial begin
        logic [7:0] hi;
        int         len;
        bus_if.mreq = 1'b0; bus_if.wr = 1'b0; bus_if.m1 = 1'b0;
        bus_if.ioreq = 1'b0; bus_if.rd = 1'b0; bus_if.a = 16'h0000;
        a_lo = 8'hFF;
        magic_button = 1'b0; magic_map = 1'b1;
        rand_cfg();
        cfg_turbo = 2'b10;
        model_reset();
        do_reset();

        // Basic config read and latency.
        rd(8'h03, 2);
        // Three frames without button, then clear-on-read of the event register.
        ticks(3);
        rd(8'h0C, 2); rd(8'h0E, 1); rd(8'h0C, 1);
        // Button held high gives one press; then saturate the counter.
        magic_button = 1'b1;
        ticks(20);
        rd(8'h0D, 2);
        for (int i = 0; i < 18; i++) begin
            magic_button = 1'b0; ticks(1);
            magic_button = 1'b1; ticks(1);
        end
        rd(8'h0D, 1); rd(8'h0D, 1); rd(8'h0C, 1);
        // Frame counter wrap and overflow flag.
        do_reset();
        ticks(256);
        rd(8'h0C, 1); rd(8'h0E, 1);
        // Tick on the clear edge, and a tick between snapshot and clear.
        step(1'b0, 1'b1, 8'h0C); step(1'b0, 1'b1, 8'h0C); step(1'b1, 1'b0, 8'h0C);
        rd(8'h0C, 1);
        step(1'b0, 1'b1, 8'h0C); step(1'b1, 1'b1, 8'h0C); step(1'b0, 1'b0, 8'h0C);
        rd(8'h0C, 1); rd(8'h0C, 1);
        // Map gating, unlisted address, ID byte, address 0.
        magic_map = 1'b0; rd(8'h03, 2); magic_map = 1'b1;
        rd(8'h20, 1); rd(8'h0F, 1); rd(8'h00, 1);
        // Map drop mid-read ends the cycle and clears.
        ticks(1);
        step(1'b0, 1'b1, 8'h0C);
        magic_map = 1'b0; step(1'b0, 1'b1, 8'h0C);
        magic_map = 1'b1; step(1'b0, 1'b0, 8'h0C);
        rd(8'h0C, 1);
        // Reset in the middle of a 0x0C read.
        ticks(2);
        step(1'b0, 1'b1, 8'h0C); step(1'b0, 1'b1, 8'h0C);
        #5 rst_n = 1'b0;
        #1;
        check("midread_reset_active", d_out_active, 1'b0);
        check("midread_reset_d_out", d_out, 8'hFF);
        bus_if.ioreq = 1'b0; bus_if.rd = 1'b0;
        repeat (2) @(posedge clk28);
        #1 rst_n = 1'b1;
        model_reset();
        rd(8'h0C, 1); rd(8'h0D, 1); rd(8'h0E, 1);

        // Randomised traffic against the model.
        for (int it = 0; it < 400; it++) begin
            if ($urandom_range(0, 3) == 0) rand_cfg();
            bus_if.m1 = 1'($urandom); bus_if.wr = 1'($urandom); bus_if.mreq = 1'($urandom);
            magic_button = 1'($urandom);
            case ($urandom_range(0, 4))
                0, 1: step(1'($urandom), 1'b0, 8'h00);
                2, 3: begin
                    hi  = ($urandom_range(0, 4) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
                    len = $urandom_range(1, 3);
                    for (int i = 0; i < len; i++) begin
                        if ($urandom_range(0, 2) == 0) rand_cfg();
                        magic_button = 1'($urandom);
                        step($urandom_range(0, 2) == 0, 1'b1, hi);
                    end
                    step($urandom_range(0, 2) == 0, 1'b0, hi);
                end
                default: begin
                    a_lo = 8'($urandom_range(0, 254));
                    step(1'b0, 1'b1, 8'h0C);
                    step(1'b0, 1'b0, 8'h0C);
                    a_lo = 8'hFF;
                end
            endcase
        end
        repeat (3) step(1'b0, 1'b0, 8'h00);
        check("queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
